// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : shared state encoding, default geometry/score limits and constants
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

  typedef enum logic [1:0] {
    ST_TITLE = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_WIN   = 2'd3
  } game_state_e;

  localparam int DEF_HOME_X       = 285;
  localparam int DEF_LEFT_LIMIT   = 160;
  localparam int DEF_RIGHT_LIMIT  = 430;
  localparam int DEF_WIN_SCORE    = 5;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int SPEED_SHIFT      = 5;
  localparam int TIMER_W          = 16;

endpackage

`default_nettype wire

// File: rtl/serve_timer.sv
// ============================================================================
// serve_timer : loadable frame countdown; done flags the last frame of a serve
// Revision    : 1.0
// ============================================================================
`default_nettype none

module serve_timer
  import game_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// ============================================================================
// game_sequencer : title/serve/play/win sequencer for a one-ball pong match
// Revision       : 1.0
// ============================================================================
`default_nettype none

module game_sequencer
  import game_pkg::*;
#(
  parameter int HOME_X       = DEF_HOME_X,
  parameter int LEFT_LIMIT   = DEF_LEFT_LIMIT,
  parameter int RIGHT_LIMIT  = DEF_RIGHT_LIMIT,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       startGame,
  input  logic       resetGame,
  input  logic       player,
  input  logic [7:0] moveSpeed,
  output logic [9:0] squareX,
  output logic [7:0] leftsc,
  output logic [7:0] rightsc,
  output logic [1:0] state,
  output logic       showTitle,
  output logic       winLeft,
  output logic       winRight,
  output logic       point
);

  localparam logic [9:0]  C_HOME  = 10'(HOME_X);
  localparam logic [10:0] C_LEFT  = 11'(LEFT_LIMIT);
  localparam logic [10:0] C_RIGHT = 11'(RIGHT_LIMIT);
  localparam logic [7:0]  C_WIN   = 8'(WIN_SCORE);
  // A zero-length serve still spends one frame in SERVE.
  localparam logic [TIMER_W-1:0] C_SERVE_LOAD =
    (SERVE_FRAMES == 0) ? TIMER_W'(1) : TIMER_W'(SERVE_FRAMES);

  game_state_e state_q, state_n;
  logic [9:0]  x_q, x_n;
  logic [7:0]  left_q, left_n, right_q, right_n;
  logic        point_q, point_n;
  logic        title_q, title_n;
  logic        winl_q, winl_n, winr_q, winr_n;
  logic        timer_load, timer_tick, timer_done;
  logic [7:0]  speed_shifted;
  logic [2:0]  step;
  logic [10:0] new_x;

  serve_timer #(.WIDTH(TIMER_W)) u_serve_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (resetGame),
    .load       (timer_load),
    .load_value (C_SERVE_LOAD),
    .tick       (timer_tick),
    .done       (timer_done)
  );

  assign speed_shifted = moveSpeed >> SPEED_SHIFT;
  assign step          = speed_shifted[2:0];
  assign new_x         = player ? ({1'b0, x_q} - {8'd0, step})
                                : ({1'b0, x_q} + {8'd0, step});

  always_comb begin
    state_n    = state_q;
    x_n        = x_q;
    left_n     = left_q;
    right_n    = right_q;
    point_n    = 1'b0;
    timer_load = 1'b0;
    timer_tick = 1'b0;

    if (resetGame) begin
      state_n = ST_TITLE;
      x_n     = C_HOME;
      left_n  = 8'd0;
      right_n = 8'd0;
    end else if (screenEnd) begin
      case (state_q)
        ST_TITLE: begin
          if (startGame) begin
            state_n    = ST_SERVE;
            timer_load = 1'b1;
            x_n        = C_HOME;
          end
        end
        ST_SERVE: begin
          x_n = C_HOME;
          if (!startGame) begin
            state_n = ST_TITLE;
          end else begin
            timer_tick = 1'b1;
            if (timer_done) state_n = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (!startGame) begin
            state_n = ST_TITLE;
            x_n     = C_HOME;
          end else if (new_x < C_LEFT) begin
            x_n = C_HOME;
            if (right_q < C_WIN) begin
              right_n = right_q + 8'd1;
              point_n = 1'b1;
            end
            if (right_n == C_WIN) begin
              state_n = ST_WIN;
            end else begin
              state_n    = ST_SERVE;
              timer_load = 1'b1;
            end
          end else if (new_x > C_RIGHT) begin
            x_n = C_HOME;
            if (left_q < C_WIN) begin
              left_n  = left_q + 8'd1;
              point_n = 1'b1;
            end
            if (left_n == C_WIN) begin
              state_n = ST_WIN;
            end else begin
              state_n    = ST_SERVE;
              timer_load = 1'b1;
            end
          end else begin
            x_n = new_x[9:0];
          end
        end
        default: begin
          x_n = C_HOME;
        end
      endcase
    end

    // Overlay flags are derived from next-state values so they stay registered.
    title_n = (state_n == ST_TITLE);
    winl_n  = (state_n == ST_WIN) && (left_n == C_WIN);
    winr_n  = (state_n == ST_WIN) && (right_n == C_WIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_TITLE;
      x_q     <= C_HOME;
      left_q  <= 8'd0;
      right_q <= 8'd0;
      point_q <= 1'b0;
      title_q <= 1'b1;
      winl_q  <= 1'b0;
      winr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      left_q  <= left_n;
      right_q <= right_n;
      point_q <= point_n;
      title_q <= title_n;
      winl_q  <= winl_n;
      winr_q  <= winr_n;
    end
  end

  assign state     = state_q;
  assign squareX   = x_q;
  assign leftsc    = left_q;
  assign rightsc   = right_q;
  assign point     = point_q;
  assign showTitle = title_q;
  assign winLeft   = winl_q;
  assign winRight  = winr_q;

endmodule

`default_nettype wire

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter HOME_X, default 285, meaning the ball serve x position in pixels.
REQ-002 The block SHALL have parameter LEFT_LIMIT, default 160, meaning the ball x below which the right side scores.
REQ-003 The block SHALL have parameter RIGHT_LIMIT, default 430, meaning the ball x above which the left side scores.
REQ-004 The block SHALL have parameter WIN_SCORE, default 5, meaning the score that ends the match.
REQ-005 The block SHALL have parameter SERVE_FRAMES, default 60, meaning the number of frames the ball is held at HOME_X after a serve.
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock (100 MHz); all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port screenEnd, input, 1 bit: one-cycle frame-boundary strobe, synchronous to clk.
REQ-009 The block SHALL have port startGame, input, 1 bit: level; high = play enabled.
REQ-010 The block SHALL have port resetGame, input, 1 bit: level; synchronous match clear.
REQ-011 The block SHALL have port player, input, 1 bit: direction; 1 = move left, 0 = move right.
REQ-012 The block SHALL have port moveSpeed, input, 8 bits: unsigned speed sample.
REQ-013 The block SHALL have port squareX, output, 10 bits: registered ball left edge.
REQ-014 The block SHALL have ports leftsc and rightsc, outputs, 8 bits each: registered scores.
REQ-015 The block SHALL have port state, output, 2 bits: current FSM state encoding.
REQ-016 The block SHALL have ports showTitle, winLeft and winRight, outputs, 1 bit each: registered overlay enables.
REQ-017 The block SHALL have port point, output, 1 bit: one-cycle pulse on any score increment.

Function
REQ-018 The FSM SHALL have states TITLE=0, SERVE=1, PLAY=2 and WIN=3; it evaluates transitions only in cycles where screenEnd=1, except for resetGame.
REQ-019 TITLE: when screenEnd=1 and startGame=1, the FSM SHALL load the serve counter with SERVE_FRAMES and go to SERVE; showTitle=1 only in TITLE.
REQ-020 SERVE: squareX SHALL equal HOME_X; on each screenEnd the counter decrements; at counter==1 with screenEnd the FSM goes to PLAY; SERVE_FRAMES=0 behaves as 1.
REQ-021 PLAY: on each screenEnd, step = moveSpeed>>5 (0..7); squareX becomes squareX-step if player=1, else squareX+step; arithmetic is 11 bits wide and no wrap is possible.
REQ-022 PLAY: if the new x < LEFT_LIMIT, then rightsc += 1, squareX=HOME_X, point=1 for one cycle, and the next state is WIN if the new rightsc==WIN_SCORE, else SERVE (counter reloaded).
REQ-023 PLAY: if the new x > RIGHT_LIMIT, the same as REQ-022 but leftsc increments; x exactly equal to a limit SHALL NOT score.
REQ-024 The scores SHALL saturate at WIN_SCORE and never increment outside PLAY; at most one side scores per frame.
REQ-025 WIN: winLeft = (leftsc==WIN_SCORE), winRight = (rightsc==WIN_SCORE); squareX is held at HOME_X; the FSM stays in WIN until resetGame.
REQ-026 In SERVE or PLAY, screenEnd with startGame=0 SHALL return the FSM to TITLE with squareX=HOME_X and the scores retained.
REQ-027 resetGame=1 SHALL, in that same clock edge regardless of screenEnd, clear the scores, set squareX=HOME_X, clear point and the winner flags, and enter TITLE; it takes priority over all other transitions.
REQ-028 All outputs SHALL be registered; updates appear one clk cycle after the edge sampling screenEnd.

Reset
REQ-029 Asserting reset SHALL immediately set state=TITLE, squareX=HOME_X, leftsc=rightsc=0, point=0, winLeft=winRight=0, showTitle=1 and the serve counter to 0, including mid-frame or mid-serve.
REQ-030 After reset deasserts, the first transition SHALL occur on the next screenEnd.

Structure
REQ-031 A shared package game_pkg SHALL hold the state encoding, the default limits, the WIN_SCORE and SERVE_FRAMES defaults, and the speed shift constant (5).
REQ-032 The serve countdown SHALL be a sub-module serve_timer (load, decrement on strobe, done flag).

Verification
REQ-033 Reset, then startGame=1 with screenEnd pulses -> state goes TITLE->SERVE; after 60 strobes it reaches PLAY with squareX=285 throughout SERVE.
REQ-034 PLAY, moveSpeed=224, player=0, 21 strobes -> squareX increases by 7 per frame; 285+7*20=425 with no score, then 432 >430 gives leftsc=1, point pulse, squareX=285, state SERVE.
REQ-035 PLAY, moveSpeed=31 (step 0) -> squareX constant for 100 frames, no score.
REQ-036 rightsc=4, ball crosses below 160 -> rightsc=5, state WIN, winRight=1, winLeft=0; further strobes leave the scores unchanged.
REQ-037 resetGame asserted in the same cycle as a scoring screenEnd -> scores are 0, point=0, state TITLE.
REQ-038 Async reset asserted mid-PLAY between clock edges -> outputs take their reset values before the next clk edge.
